// File: rtl/traffic_light_pkg.sv
// Shared phase encoding and helpers for the traffic-light controller.
package traffic_light_pkg;

    typedef enum logic [1:0] {
        ST_RED    = 2'b00,
        ST_GREEN  = 2'b01,
        ST_YELLOW = 2'b10,
        ST_BAD    = 2'b11
    } phase_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Dwell counter width; a single bit even when every phase lasts one cycle.
    function automatic int dwell_width(input int a, input int b, input int c);
        int m;
        m = max3(a, b, c);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    function automatic phase_t next_phase(input phase_t p);
        case (p)
            ST_RED:    return ST_GREEN;
            ST_GREEN:  return ST_YELLOW;
            ST_YELLOW: return ST_RED;
            default:   return ST_RED;
        endcase
    endfunction

endpackage

// File: rtl/tl_dwell_timer.sv
// Up-counter that pulses done on reaching the terminal count, then wraps to zero.
module tl_dwell_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic [W-1:0] terminal,
    output logic         done,
    output logic [W-1:0] count
);

    assign done = (count == terminal);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear || done) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/traffic_light.sv
// Moore traffic-light FSM: RED -> GREEN -> YELLOW -> RED with per-phase dwell lengths.
module traffic_light
    import traffic_light_pkg::*;
#(
    parameter int RED_CYCLES    = 3,
    parameter int GREEN_CYCLES  = 3,
    parameter int YELLOW_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    output logic [1:0] state,
    output logic       red,
    output logic       green,
    output logic       yellow
);

    localparam int W = dwell_width(RED_CYCLES, GREEN_CYCLES, YELLOW_CYCLES);
    localparam logic [W-1:0] TC_RED    = W'(RED_CYCLES - 1);
    localparam logic [W-1:0] TC_GREEN  = W'(GREEN_CYCLES - 1);
    localparam logic [W-1:0] TC_YELLOW = W'(YELLOW_CYCLES - 1);

    if (RED_CYCLES < 1 || GREEN_CYCLES < 1 || YELLOW_CYCLES < 1) begin : g_bad_param
        $fatal(1, "traffic_light: every phase duration must be >= 1");
    end

    phase_t         state_q;
    phase_t         state_d;
    logic [W-1:0]   terminal;
    logic [W-1:0]   count;
    logic           done;
    logic           clear;

    // An upset into the unused encoding also restarts the dwell timer.
    assign clear = (state_q == ST_BAD);

    tl_dwell_timer #(.W(W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .terminal (terminal),
        .done     (done),
        .count    (count)
    );

    // NOTE: defaults are assigned first so no path through this block can infer a latch.
    always_comb begin
        state_d  = state_q;
        terminal = '0;
        case (state_q)
            ST_RED:    terminal = TC_RED;
            ST_GREEN:  terminal = TC_GREEN;
            ST_YELLOW: terminal = TC_YELLOW;
            default:   terminal = '0;
        endcase
        if (clear) begin
            state_d = ST_RED;
        end else if (done) begin
            state_d = next_phase(state_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state  = state_q;
    assign red    = (state_q == ST_RED);
    assign green  = (state_q == ST_GREEN);
    assign yellow = (state_q == ST_YELLOW);

endmodule

// File: tb/tb_traffic_light.sv
// Randomized scoreboard bench for traffic_light, default and overridden dwell lengths.
module tb_traffic_light;
    import traffic_light_pkg::*;

    localparam int A_R = 3, A_G = 3, A_Y = 1;
    localparam int B_R = 1, B_G = 2, B_Y = 4;
    localparam int PA = A_R + A_G + A_Y;
    localparam int PB = B_R + B_G + B_Y;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] state_a, state_b;
    logic       red_a, green_a, yellow_a;
    logic       red_b, green_b, yellow_b;

    traffic_light dut_a (
        .clk(clk), .rst(rst), .state(state_a),
        .red(red_a), .green(green_a), .yellow(yellow_a)
    );

    traffic_light #(.RED_CYCLES(B_R), .GREEN_CYCLES(B_G), .YELLOW_CYCLES(B_Y)) dut_b (
        .clk(clk), .rst(rst), .state(state_b),
        .red(red_b), .green(green_b), .yellow(yellow_b)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   pos_a       = 0;
    int   pos_b       = 0;

    // Reference: position within the light period maps straight onto a phase.
    function automatic logic [1:0] phase_at(input int pos, input int r, input int g);
        if (pos < r)          return 2'b00;
        else if (pos < r + g) return 2'b01;
        else                  return 2'b10;
    endfunction

    function automatic logic [2:0] lamps_of(input logic [1:0] p);
        return {p == 2'b00, p == 2'b01, p == 2'b10};
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("state_a", {2'b00, state_a}, {2'b00, e.a});
            check("lamps_a", {1'b0, red_a, green_a, yellow_a}, {1'b0, lamps_of(e.a)});
            check("state_b", {2'b00, state_b}, {2'b00, e.b});
            check("lamps_b", {1'b0, red_b, green_b, yellow_b}, {1'b0, lamps_of(e.b)});
        end
    end

    // One clock of stimulus; upset drives dut_a into the unused encoding before the edge.
    task automatic step(input logic r, input bit upset);
        exp_t e;
        @(negedge clk);
        #2;
        rst = r;
        if (upset) begin
            force dut_a.state_q = ST_BAD;
            #1;
            release dut_a.state_q;
        end
        @(posedge clk);
        #1;
        pos_a = (r || upset) ? 0 : (pos_a + 1) % PA;
        pos_b = r ? 0 : (pos_b + 1) % PB;
        e.a = phase_at(pos_a, A_R, A_G);
        e.b = phase_at(pos_b, B_R, B_G);
        sb_q.push_back(e);
    endtask

    initial begin
        step(1'b1, 1'b0);
        repeat (8 + 3 * PA) step(1'b0, 1'b0);

        // Walk dut_a to GREEN with counter 1, then reset mid-phase.
        for (int i = 0; i < PA && pos_a != A_R + 1; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (PA + 1) step(1'b0, 1'b0);

        repeat (80) step(($urandom_range(0, 15) == 0), 1'b0);

        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (10) step(1'b0, 1'b0);

        repeat (2) @(negedge clk);
        #1;
        check("sb_drain", 4'(sb_q.size()), 4'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
